bus_gnrtr_n_rbtr: RTL and testbench
===================================

// Module: bus_gnrtr_n_rbtr
// PURPOSE
//  Shared-bus generator and arbiter linking `drvrs` terminals. Each terminal presents an input FIFO
//  (pndng/D_pop, drained by pop) and an output FIFO (D_push, loaded by push). The block grants one
//  pending terminal at a time round-robin, pops its packet and routes it by destination ID.
//  Sits between the terminal FIFOs/drivers and the system bus model.
// PARAMETERS
//  drvrs      4      number of terminals on the bus (2..16)
//  pckg_sz    16     packet width in bits; [pckg_sz-1 -: 8] = destination ID, rest = payload
//  broadcast  8'hFF  destination ID meaning "all terminals except source"
// PORTS
//  clk      in   1                 system clock, rising edge
//  reset    in   1                 asynchronous, active-high reset
//  pndng    in   [drvrs]           terminal i input FIFO not empty
//  pop      out  [drvrs]           1-cycle read strobe to terminal i input FIFO
//  D_pop    in   [drvrs][pckg_sz]  head word of terminal i input FIFO (valid while pndng[i])
//  push     out  [drvrs]           1-cycle write strobe to terminal i output FIFO
//  D_push   out  [drvrs][pckg_sz]  packet driven to terminal i output FIFO
// BEHAVIOUR
//  - Reset (async assert, sync release): pop=0, push=0, D_push=0, FSM=IDLE, rr pointer so term 0 first.
//  - FSM IDLE: if |pndng, pick grant g = first i with pndng[i] searching from last_grant+1 (mod drvrs);
//    register g; -> POP. Else stay IDLE.
//  - POP (1 cycle): pop[g]=1, all other pop=0; D_pop[g] latched into pkt at cycle end; last_grant<=g; -> PUSH.
//  - PUSH (1 cycle): D_push[i]=pkt for every i; push[i]=1 where i==dest(pkt) and dest<drvrs;
//    if dest==broadcast, push[i]=1 for all i!=g; -> IDLE.
//  - Latency: pndng rise to pop = 1 clk; pop to push = 1 clk; max throughput 1 packet / 3 clk.
//  - dest==g (self-addressed, non-broadcast): delivered to g normally.
//  - dest>=drvrs and !=broadcast: packet consumed, no push (dropped); pkt still shown on D_push.
//  - pndng deasserted by the time POP is reached is not possible by contract (only DUT pops);
//    if it occurs, pop still pulses and the latched word is routed as is.
//  - Simultaneous pndng: strict round-robin; a terminal waits at most drvrs-1 grants.
//  - D_push holds last pkt between transfers; only push qualifies it.
//  - Reset mid-transfer: packet in flight is lost, strobes drop immediately (async).
// CONFIGURATION
//  GNRTR_BROADCAST_EN defined: broadcast ID handled as above.
//  Not defined: broadcast ID treated as an ordinary out-of-range ID -> packet dropped, no push.
// STRUCTURE
//  Package bus_pkg: typedef fsm_state_e {IDLE,POP,PUSH}; localparam ID_W=8; function
//  get_dest(pkt) returning pkt[pckg_sz-1 -: ID_W].
//  Sub-module rr_arbiter #(drvrs): req=pndng, en=(state==IDLE), outputs one-hot grant and index;
//  owns the last_grant pointer. Top holds FSM, packet register and routing decode.
// TESTING (drvrs=4, pckg_sz=16)
//  1. Reset 50ns with pndng=4'hF -> pop=push=0, D_push=0 throughout reset.
//  2. Term0 D_pop=16'h02AB, pndng[0]=1 -> pop[0] 1 clk later, then push[2]=1 with D_push[2]=16'h02AB.
//  3. pndng=4'b1111, all packets to dest 1 -> pops in order 0,1,2,3, four push[1] pulses, 3 clk apart.
//  4. Term3 sends 16'hFF5A (macro on) -> push=4'b0111, D_push=16'hFF5A; macro off -> push stays 0.
//  5. Term1 sends 16'h0711 (dest 7) -> pop[1] pulses, no push; next pending term served normally.
//  6. Assert reset during PUSH state -> push falls same cycle, FSM IDLE, next grant goes to term 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus generator/arbiter: FSM states, ID width, destination decode.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } fsm_state_e;

  localparam int ID_W    = 8;
  localparam int PKT_MAX = 64;

  // Destination ID lives in the top byte of the packet; callers zero-extend to PKT_MAX.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt, input int pckg_sz);
    return pkt[pckg_sz-1 -: ID_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last granted index and owns that pointer.
module rr_arbiter #(
  parameter int drvrs = 4,
  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [drvrs-1:0] req,
  input  logic             en,
  output logic [drvrs-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_vld
);

  logic [IW-1:0] last_grant;
  int            cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 1; k <= drvrs; k++) begin
      cand = (int'(last_grant) + k) % drvrs;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(cand);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  // Pointer starts at the last terminal so terminal 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant <= IW'(drvrs - 1);
    else if (en && grant_vld) last_grant <= grant_idx;
  end

endmodule

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus generator/arbiter: grants one pending terminal round-robin, pops its packet and routes it
// by destination ID. Define GNRTR_BROADCAST_EN to deliver the broadcast ID to all terminals but the source.
// Handshake: pop[i] and push[i] are single-cycle strobes; a word is taken from D_pop[g] on the cycle
// pop[g] is high, and D_push is only meaningful on the cycle the matching push bit is high.
module bus_gnrtr_n_rbtr
  import bus_pkg::*;
#(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic [1:0]                      dbg_state
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
`ifdef GNRTR_BROADCAST_EN
  localparam logic BCAST_EN = 1'b1;
`else
  localparam logic BCAST_EN = 1'b0;
`endif

  fsm_state_e       state;
  logic [IW-1:0]    g;
  logic [drvrs-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_vld;
  logic [pckg_sz-1:0] pop_word;
  logic [ID_W-1:0]  dest;
  logic [drvrs-1:0] route;

  rr_arbiter #(.drvrs(drvrs)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pndng),
    .en        (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign pop_word  = D_pop[g];
  assign dbg_state = state;

  // Without broadcast support the broadcast ID is simply out of range and the packet is dropped.
  always_comb begin
    route = '0;
    dest  = get_dest(PKT_MAX'(pop_word), pckg_sz);
    for (int i = 0; i < drvrs; i++) begin
      if (dest == ID_W'(i)) route[i] = 1'b1;
    end
    if (BCAST_EN && dest == broadcast) begin
      route    = '1;
      route[g] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      g      <= '0;
      pop    <= '0;
      push   <= '0;
      D_push <= '0;
    end else begin
      case (state)
        IDLE: begin
          push <= '0;
          if (grant_vld) begin
            g     <= grant_idx;
            pop   <= grant;
            state <= POP;
          end
        end
        POP: begin
          pop    <= '0;
          push   <= route;
          D_push <= {drvrs{pop_word}};
          state  <= PUSH;
        end
        PUSH: begin
          push  <= '0;
          state <= IDLE;
        end
        default: begin
          pop   <= '0;
          push  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Bench for bus_gnrtr_n_rbtr with four terminals and 16-bit packets, terminal FIFOs modelled as queues.
module tb_bus_gnrtr_n_rbtr;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       pndng = '0;
  logic [3:0]       pop;
  logic [3:0][15:0] D_pop = '0;
  logic [3:0]       push;
  logic [3:0][15:0] D_push;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] term_q[4][$];
  logic [3:0]  exp_pop_q[$];
  logic [3:0]  exp_push_q[$];
  logic [15:0] exp_data_q[$];
  int          pop_cyc_q[$];
  int          push_cyc_q[$];
  logic [3:0]  pop_pend = '0;
  logic [3:0]  mon_e;
  logic [15:0] mon_d;

  bus_gnrtr_n_rbtr #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (D_pop),
    .push      (push),
    .D_push    (D_push),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Terminal FIFO model plus scoreboard monitor, both on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (pop != 4'b0) begin
        checks++;
        pop_cyc_q.push_back(cyc);
        if (exp_pop_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: pop=%b required none", pop);
        end else begin
          mon_e = exp_pop_q.pop_front();
          if (pop !== mon_e) begin
            errors++;
            $display("FAIL pop_order: pop=%b required %b", pop, mon_e);
          end
        end
      end
      if (push != 4'b0) begin
        checks++;
        push_cyc_q.push_back(cyc);
        if (exp_push_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: push=%b D_push[0]=%h required none", push, D_push[0]);
        end else begin
          mon_e = exp_push_q.pop_front();
          mon_d = exp_data_q.pop_front();
          if (push !== mon_e) begin
            errors++;
            $display("FAIL push_mask: push=%b required %b", push, mon_e);
          end
          for (int i = 0; i < 4; i++) begin
            if (D_push[i] !== mon_d) begin
              errors++;
              $display("FAIL push_data[%0d]: D_push=%h required %h", i, D_push[i], mon_d);
            end
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pop_pend[i] && term_q[i].size() > 0) void'(term_q[i].pop_front());
    end
    pop_pend = pop;
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (term_q[i].size() > 0);
      D_pop[i] = (term_q[i].size() > 0) ? term_q[i][0] : 16'h0;
    end
  end

  // driver tasks
  function automatic logic [3:0] route_model(input int src, input logic [15:0] w);
    logic [3:0] m;
    logic [7:0] dest;
    m = '0;
    dest = w[15:8];
    if (dest < 8'd4) m[dest[1:0]] = 1'b1;
`ifdef GNRTR_BROADCAST_EN
    if (dest == 8'hFF) begin
      m = 4'hF;
      m[src] = 1'b0;
    end
`endif
    return m;
  endfunction

  // Calls must be made in the order the arbiter is expected to serve them.
  task automatic send(input int src, input logic [15:0] w);
    logic [3:0] oh;
    logic [3:0] m;
    oh = '0;
    oh[src] = 1'b1;
    term_q[src].push_back(w);
    exp_pop_q.push_back(oh);
    m = route_model(src, w);
    if (m != 4'b0) begin
      exp_push_q.push_back(m);
      exp_data_q.push_back(w);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) term_q[i].delete();
    exp_pop_q.delete();
    exp_push_q.delete();
    exp_data_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_pop_q.size() != 0 || exp_push_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_pop_q.size() != 0 || exp_push_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d pops and %0d pushes outstanding, required 0", name,
               exp_pop_q.size(), exp_push_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) term_q[i].push_back(16'h0100 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pop !== 4'b0 || push !== 4'b0 || D_push !== '0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: pop=%b push=%b D_push=%h state=%0d required all zero",
                 pop, push, D_push, dbg_state);
      end
    end
    for (int i = 0; i < 4; i++) term_q[i].delete();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_single();
    int rise, pb, qb;
    do_reset();
    @(posedge clk);
    #2;
    pb = pop_cyc_q.size();
    qb = push_cyc_q.size();
    send(0, 16'h02AB);
    @(negedge clk);
    rise = cyc;
    wait_drain("single", 20);
    checks++;
    if (pop_cyc_q.size() <= pb || pop_cyc_q[pb] !== rise + 1) begin
      errors++;
      $display("FAIL single_pop_latency: pop cycle=%0d required %0d",
               (pop_cyc_q.size() > pb) ? pop_cyc_q[pb] : -1, rise + 1);
    end
    checks++;
    if (push_cyc_q.size() <= qb || push_cyc_q[qb] !== rise + 2) begin
      errors++;
      $display("FAIL single_push_latency: push cycle=%0d required %0d",
               (push_cyc_q.size() > qb) ? push_cyc_q[qb] : -1, rise + 2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (D_push[2] !== 16'h02AB || push !== 4'b0) begin
      errors++;
      $display("FAIL single_hold: D_push[2]=%h push=%b required 02ab and 0000", D_push[2], push);
    end
  endtask

  task automatic test_round_robin();
    int qb;
    do_reset();
    @(posedge clk);
    #2;
    qb = push_cyc_q.size();
    for (int i = 0; i < 4; i++) send(i, 16'h01A0 + 16'(i));
    wait_drain("round_robin", 40);
    checks++;
    if (push_cyc_q.size() - qb !== 4) begin
      errors++;
      $display("FAIL rr_push_count: pushes=%0d required 4", push_cyc_q.size() - qb);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (push_cyc_q[qb + k] - push_cyc_q[qb + k - 1] !== 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: gap=%0d required 3", k,
                   push_cyc_q[qb + k] - push_cyc_q[qb + k - 1]);
        end
      end
    end
  endtask

  task automatic test_broadcast();
    int qb, want;
    do_reset();
    @(posedge clk);
    #2;
    qb = push_cyc_q.size();
    send(3, 16'hFF5A);
    wait_drain("broadcast", 20);
`ifdef GNRTR_BROADCAST_EN
    want = 1;
`else
    want = 0;
`endif
    checks++;
    if (push_cyc_q.size() - qb !== want) begin
      errors++;
      $display("FAIL bcast_push_count: pushes=%0d required %0d", push_cyc_q.size() - qb, want);
    end
    checks++;
    if (D_push[0] !== 16'hFF5A) begin
      errors++;
      $display("FAIL bcast_data: D_push[0]=%h required ff5a", D_push[0]);
    end
  endtask

  task automatic test_drop();
    int qb, n;
    do_reset();
    @(posedge clk);
    #2;
    qb = push_cyc_q.size();
    send(1, 16'h0711);
    send(2, 16'h0122);
    n = 0;
    while (exp_pop_q.size() == 2 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (D_push[3] !== 16'h0711 || push !== 4'b0) begin
      errors++;
      $display("FAIL drop_shown: D_push[3]=%h push=%b required 0711 and 0000", D_push[3], push);
    end
    wait_drain("drop", 20);
    checks++;
    if (push_cyc_q.size() - qb !== 1 || D_push[0] !== 16'h0122) begin
      errors++;
      $display("FAIL drop_next: pushes=%0d D_push[0]=%h required 1 and 0122",
               push_cyc_q.size() - qb, D_push[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(posedge clk);
    #2;
    term_q[1].push_back(16'h0310);
    exp_pop_q.push_back(4'b0010);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dbg_state !== 2'd2 && n < 20);
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL mid_reach_push: state=%0d required 2", dbg_state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (push !== 4'b0 || dbg_state !== 2'd0 || D_push !== '0) begin
      errors++;
      $display("FAIL mid_reset: push=%b state=%0d D_push=%h required 0000, 0, 0",
               push, dbg_state, D_push);
    end
    exp_pop_q.delete();
    send(0, 16'h0200);
    send(3, 16'h0133);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    wait_drain("mid_reset", 20);
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_broadcast();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
